// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core MEM stage and a loader port.
// The core has priority, the loader is protected from starvation, and the loader may lock memory for bursts.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int STARVE_MAX = 8
) (
    input  logic                              i_clk,
    input  logic                              i_reset_n,
    // core port
    input  logic                              i_c_req,
    input  logic                              i_c_we,
    input  logic [ADDR_WIDTH-1:0]             i_c_addr,
    input  logic [DATA_WIDTH-1:0]             i_c_wdata,
    input  logic [DATA_BYTES-1:0]             i_c_be,
    output logic                              o_c_gnt,
    output logic                              o_c_rvalid,
    output logic [DATA_WIDTH-1:0]             o_c_rdata,
    output logic                              o_c_stall,
    // loader port
    input  logic                              i_d_req,
    input  logic                              i_d_we,
    input  logic [ADDR_WIDTH-1:0]             i_d_addr,
    input  logic [DATA_WIDTH-1:0]             i_d_wdata,
    input  logic [DATA_BYTES-1:0]             i_d_be,
    input  logic                              i_d_lock,
    output logic                              o_d_gnt,
    output logic                              o_d_rvalid,
    output logic [DATA_WIDTH-1:0]             o_d_rdata,
    // memory side
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic [DATA_WIDTH-1:0]             o_mem_wdata,
    output logic                              o_mem_we,
    output logic [DATA_BYTES-1:0]             o_mem_be,
    input  logic [DATA_WIDTH-1:0]             i_mem_rdata,
    // debug visibility of the arbitration state
    output logic                              dbg_state,
    output logic [$clog2(STARVE_MAX+1)-1:0]   dbg_starve
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic {
        OPEN  = 1'b0,
        DLOCK = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             rd_pend;
    logic             rd_owner;   // 1 = loader owns the pending read
    logic             c_gnt;
    logic             d_gnt;

    // Core wins in OPEN unless the loader has waited STARVE_MAX cycles; DLOCK excludes the core.
    assign c_gnt = (state == OPEN) && i_c_req && (starve_cnt < STARVE_LIM);
    assign d_gnt = i_d_req && !c_gnt;

    assign o_c_gnt    = c_gnt;
    assign o_d_gnt    = d_gnt;
    assign o_c_stall  = i_c_req && !c_gnt;
    assign o_c_rvalid = rd_pend && !rd_owner;
    assign o_d_rvalid = rd_pend && rd_owner;
    assign o_c_rdata  = o_c_rvalid ? i_mem_rdata : '0;
    assign o_d_rdata  = o_d_rvalid ? i_mem_rdata : '0;
    assign dbg_state  = state;
    assign dbg_starve = starve_cnt;

    always_comb begin
        o_mem_addr  = i_c_addr;
        o_mem_wdata = i_c_wdata;
        o_mem_we    = 1'b0;
        o_mem_be    = '0;
        if (c_gnt) begin
            o_mem_we = i_c_we;
            o_mem_be = i_c_be;
        end else if (d_gnt) begin
            o_mem_addr  = i_d_addr;
            o_mem_wdata = i_d_wdata;
            o_mem_we    = i_d_we;
            o_mem_be    = i_d_be;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= OPEN;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            case (state)
                OPEN:    if (d_gnt && i_d_lock) state <= DLOCK;
                DLOCK:   if (!i_d_lock) state <= OPEN;
                default: state <= OPEN;
            endcase

            if (i_d_req && !d_gnt)
                starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt : starve_cnt + 1'b1;
            else
                starve_cnt <= '0;

            // Memory data arrives one cycle after the access edge, so the owner is tagged here.
            rd_pend  <= (c_gnt && !i_c_we) || (d_gnt && !i_d_we);
            rd_owner <= d_gnt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table of requests with hand-derived grants, plus a
// read-response scoreboard fed from a reference copy of a behavioural memory.
module tb_dmem_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk;
    logic          rst_n;
    logic          c_req, c_we, d_req, d_we, d_lock;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic [BW-1:0] c_be, d_be;
    logic          c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
    logic [DW-1:0] c_rdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic          dbg_state;
    logic [3:0]    dbg_starve;

    dmem_arbiter dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata), .i_c_be(c_be),
        .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata), .o_c_stall(c_stall),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
        .i_d_lock(d_lock), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we), .o_mem_be(mem_be),
        .i_mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_starve(dbg_starve)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'hA500_0000 ^ ({21'd0, a} << 12) ^ {21'd0, a};
    endfunction

    // behavioural memory: synchronous read, byte-enabled write
    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(AW'(i));
            mem_loaded <= 1'b1;
        end else if (mem_we) begin
            for (int b = 0; b < BW; b++)
                if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= mem[mem_addr];
    end

    // scoreboard
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW:0]   exp_q[$];   // {owner (1 = loader), data}
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic          c_req, c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata;
        logic [BW-1:0] c_be;
        logic          d_req, d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic [BW-1:0] d_be;
        logic          d_lock;
        logic          exp_c_gnt, exp_d_gnt, exp_state;
        logic [3:0]    exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cr, input logic cw, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cd, input logic [BW-1:0] cb,
                                input logic dr, input logic dw, input logic [AW-1:0] da,
                                input logic [DW-1:0] dd, input logic [BW-1:0] db, input logic dl,
                                input logic ec, input logic ed, input logic es, input logic [3:0] en);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd; v.c_be = cb;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.d_be = db; v.d_lock = dl;
        v.exp_c_gnt = ec; v.exp_d_gnt = ed; v.exp_state = es; v.exp_cnt = en;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_resp();
        logic [DW:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("c_rvalid", c_rvalid, !e[DW]);
            check("d_rvalid", d_rvalid, e[DW]);
            check("c_rdata", c_rdata, e[DW] ? '0 : e[DW-1:0]);
            check("d_rdata", d_rdata, e[DW] ? e[DW-1:0] : '0);
        end else begin
            check("c_rvalid_idle", c_rvalid, 0);
            check("d_rvalid_idle", d_rvalid, 0);
            check("rdata_idle", {c_rdata, d_rdata}, 0);
        end
    endtask

    task automatic account(input logic owner, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [BW-1:0] be);
        if (we) begin
            for (int b = 0; b < BW; b++)
                if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
            exp_q.push_back({owner, ref_mem[a]});
        end
    endtask

    task automatic drive_idle();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0; d_lock = 0;
    endtask

    // driver: one cycle per vector, checked between negedge and the next rising edge
    task automatic step(input vec_t v);
        @(negedge clk);
        c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata; c_be = v.c_be;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata; d_be = v.d_be;
        d_lock = v.d_lock;
        #1;
        check("c_gnt", c_gnt, v.exp_c_gnt);
        check("d_gnt", d_gnt, v.exp_d_gnt);
        check("c_stall", c_stall, v.c_req & ~v.exp_c_gnt);
        check("state", dbg_state, v.exp_state);
        check("starve", dbg_starve, v.exp_cnt);
        if (v.exp_c_gnt) begin
            check("mem_c", {mem_addr, mem_we, mem_be}, {v.c_addr, v.c_we, v.c_be});
            if (v.c_we) check("mem_wdata_c", mem_wdata, v.c_wdata);
        end else if (v.exp_d_gnt) begin
            check("mem_d", {mem_addr, mem_we, mem_be}, {v.d_addr, v.d_we, v.d_be});
            if (v.d_we) check("mem_wdata_d", mem_wdata, v.d_wdata);
        end else begin
            check("mem_idle", {mem_we, mem_be}, 0);
        end
        check_resp();
        if (v.exp_c_gnt) account(1'b0, v.c_we, v.c_addr, v.c_wdata, v.c_be);
        else if (v.exp_d_gnt) account(1'b1, v.d_we, v.d_addr, v.d_wdata, v.d_be);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(AW'(i));
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rvalid", {c_rvalid, d_rvalid}, 0);
        check("rst_rdata", {c_rdata, d_rdata}, 0);
        check("rst_state", dbg_state, 0);
        check("rst_starve", dbg_starve, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // core read/write, byte lanes, alternating ports, contention and counter clear
        vecs.push_back(mk(1,0,11'h010,0,4'hF,            0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,1,11'h011,32'hDEADBEEF,4'hF, 0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,11'h012,32'h11223344,4'h5, 0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,11'h011,0,4'hF,            0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,11'h012,0,4'hF,            0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,                     1,0,11'h021,0,4'hF,0, 0,1,0,0));
        vecs.push_back(mk(1,0,11'h020,0,4'hF,            0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,                     1,0,11'h023,0,4'hF,0, 0,1,0,0));
        vecs.push_back(mk(1,0,11'h022,0,4'hF,            0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,                     1,1,11'h022,32'hCAFEF00D,4'hF,0, 0,1,0,0));
        vecs.push_back(mk(1,0,11'h022,0,4'hF,            0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(1,0,11'h030,0,4'hF,            1,0,11'h031,0,4'hF,0, 1,0,0,0));
        vecs.push_back(mk(1,0,11'h030,0,4'hF,            1,0,11'h031,0,4'hF,0, 1,0,0,1));
        vecs.push_back(mk(1,0,11'h030,0,4'hF,            1,0,11'h031,0,4'hF,0, 1,0,0,2));
        vecs.push_back(mk(1,0,11'h030,0,4'hF,            0,0,0,0,0,0, 1,0,0,3));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,0,0,0, 0,0,0,0));
        // both ports held: eight core grants, then a forced loader grant, twice
        for (int i = 0; i < 18; i++)
            vecs.push_back(mk(1,0,AW'(11'h100+i),0,4'hF, 1,0,AW'(11'h200+i),0,4'hF,0,
                              (i % 9) != 8, (i % 9) == 8, 0, 4'(i % 9)));
        // locked loader burst with the core stalled, then lock released
        vecs.push_back(mk(0,0,0,0,0,                     1,0,11'h040,0,4'hF,1, 0,1,0,0));
        vecs.push_back(mk(1,0,11'h050,0,4'hF,            1,0,11'h041,0,4'hF,1, 0,1,1,0));
        vecs.push_back(mk(1,0,11'h050,0,4'hF,            1,0,11'h042,0,4'hF,1, 0,1,1,0));
        vecs.push_back(mk(1,0,11'h050,0,4'hF,            1,0,11'h043,0,4'hF,1, 0,1,1,0));
        vecs.push_back(mk(1,0,11'h050,0,4'hF,            0,0,0,0,0,1, 0,0,1,0));
        vecs.push_back(mk(1,0,11'h050,0,4'hF,            0,0,0,0,0,0, 0,0,1,0));
        vecs.push_back(mk(1,0,11'h050,0,4'hF,            0,0,0,0,0,0, 1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,                     0,0,0,0,0,0, 0,0,0,0));

        foreach (vecs[i]) step(vecs[i]);

        // asynchronous reset with a locked loader read outstanding
        step(mk(0,0,0,0,0, 1,0,11'h060,0,4'hF,1, 0,1,0,0));
        @(posedge clk);
        #2 rst_n = 1'b0;
        drive_idle();
        exp_q.delete();
        #1;
        check("arst_d_rvalid", d_rvalid, 0);
        check("arst_d_rdata", d_rdata, 0);
        check("arst_state", dbg_state, 0);
        check("arst_starve", dbg_starve, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(mk(1,0,11'h070,0,4'hF, 0,0,0,0,0,0, 1,0,0,0));
        step(mk(0,0,0,0,0,          0,0,0,0,0,0, 0,0,0,0));
        step(mk(0,0,0,0,0,          0,0,0,0,0,0, 0,0,0,0));
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning the data-memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the data word width.
REQ-003 SHALL have parameter DATA_BYTES, default DATA_WIDTH/8, meaning the byte-lane count.
REQ-004 SHALL have parameter STARVE_MAX, default 8, meaning the number of loader wait cycles before the loader gets a forced grant.
REQ-005 SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 SHALL have core-port inputs: i_c_req 1, i_c_we 1, i_c_addr ADDR_WIDTH, i_c_wdata DATA_WIDTH, i_c_be DATA_BYTES (MEM-stage access).
REQ-008 SHALL have core-port outputs: o_c_gnt 1 (request accepted this cycle), o_c_rvalid 1, o_c_rdata DATA_WIDTH, o_c_stall 1 (core request pending but not granted).
REQ-009 SHALL have loader-port inputs: i_d_req 1, i_d_we 1, i_d_addr ADDR_WIDTH, i_d_wdata DATA_WIDTH, i_d_be DATA_BYTES, i_d_lock 1 (hold memory across a burst).
REQ-010 SHALL have loader-port outputs: o_d_gnt 1, o_d_rvalid 1, o_d_rdata DATA_WIDTH.
REQ-011 SHALL have memory-side outputs o_mem_addr ADDR_WIDTH, o_mem_wdata DATA_WIDTH, o_mem_we 1, o_mem_be DATA_BYTES, and input i_mem_rdata DATA_WIDTH (valid one cycle after the access edge).

Function
REQ-012 SHALL keep a two-state FSM: OPEN (per-cycle arbitration) and DLOCK (loader owns memory).
REQ-013 In OPEN SHALL grant the core when i_c_req=1 and the starve counter is below STARVE_MAX; otherwise SHALL grant the loader if i_d_req=1.
REQ-014 SHALL assert at most one of o_c_gnt / o_d_gnt per cycle; grants are combinational from current requests and state.
REQ-015 SHALL drive memory outputs from the granted requester's fields; with no grant o_mem_we=0 and o_mem_be=0, addr/wdata don't-care.
REQ-016 Starve counter: SHALL increment (saturating at STARVE_MAX) when i_d_req=1 and o_d_gnt=0; SHALL clear when o_d_gnt=1 or i_d_req=0.
REQ-017 When the counter equals STARVE_MAX and i_d_req=1 SHALL grant the loader even with i_c_req=1.
REQ-018 OPEN->DLOCK SHALL occur on the edge where o_d_gnt=1 and i_d_lock=1.
REQ-019 In DLOCK SHALL never grant the core; SHALL grant the loader whenever i_d_req=1.
REQ-020 DLOCK->OPEN SHALL occur on the edge where i_d_lock=0; the core is eligible in the following cycle.
REQ-021 o_c_stall SHALL equal i_c_req AND NOT o_c_gnt.
REQ-022 SHALL register the owner of each granted read (we=0); on the next cycle SHALL pulse that owner's rvalid for one cycle with rdata=i_mem_rdata.
REQ-023 Granted writes SHALL produce no rvalid on either port.
REQ-024 Non-owner rdata SHALL be held at zero; both rvalid outputs SHALL never be high together.
REQ-025 Back-to-back grants SHALL be accepted every cycle with no bubble; a read response and a new grant may coincide.

Reset
REQ-026 While i_reset_n=0: FSM=OPEN, starve counter=0, pending-read flag=0, o_c_rvalid=o_d_rvalid=0, o_c_rdata=o_d_rdata=0.
REQ-027 Reset assertion SHALL act immediately without a clock edge, also mid-DLOCK or with a read pending; the pending response SHALL be discarded.
REQ-028 After deassertion the first edge SHALL arbitrate normally from OPEN.

Verification
REQ-029 Core-only read addr 0x010, then write 0xDEADBEEF be=0xF to 0x011 -> o_c_gnt both cycles; o_c_rvalid one cycle after the read only; o_mem_we=1 only on the write cycle.
REQ-030 i_c_req and i_d_req held high continuously -> core granted 8 cycles, loader granted on the 9th, counter back to 0, pattern repeats.
REQ-031 Loader grant with i_d_lock=1, four reads, then i_d_lock=0 while i_c_req=1 -> o_c_stall=1 throughout DLOCK, core granted the cycle after lock drops, four o_d_rvalid pulses in order.
REQ-032 Loader read granted then i_reset_n pulsed low before next edge -> o_d_rvalid stays 0, FSM OPEN, counter 0.
REQ-033 Alternating core read / loader read every cycle -> rvalid routed to the correct port each cycle, never both high, rdata matching memory contents.
